rps_match_scorer: RTL and testbench
===================================

# rps_match_scorer

Match-level scoreboard directly downstream of the rock-paper-scissors round engine. Consumes one 2-bit round outcome per `round_valid` strobe, tallies user wins, computer wins and draws, and declares a best-of match winner when either side reaches `WIN_TARGET` wins. Holds the final result until a new match is started. Feeds the display/score-readout logic.

## Interface
Parameters:
- `WIN_TARGET`, 3: wins needed to take the match; legal range 1 .. 2^`CNT_W`-1.
- `CNT_W`, 4: width of every counter output.
- `MAX_ROUNDS`, 9: round limit; used only with `RPS_ROUND_LIMIT_EN`; legal range 1 .. 2^`CNT_W`-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin or restart a match; level sampled each edge.
- `round_valid`  in  1  `win` holds a new round outcome this cycle.
- `win`  in  2  round outcome: 00 user wins, 01 draw, 11 computer wins, 10 illegal.
- `user_score`  out  `CNT_W`  user round wins this match.
- `comp_score`  out  `CNT_W`  computer round wins this match.
- `draw_count`  out  `CNT_W`  drawn rounds this match.
- `round_count`  out  `CNT_W`  legal rounds scored this match.
- `busy`  out  1  high in PLAY.
- `match_done`  out  1  high in DONE.
- `match_result`  out  2  match winner, same encoding as `win`; 01 when no winner.
- `err`  out  1  sticky flag: an illegal code 10 was received in PLAY.

## Operation
- FSM states: IDLE, PLAY, DONE. State is encoded internally; `busy` and `match_done` are decoded from it as registered outputs.
- Reset (`reset`=0 at an edge):
  - State goes to IDLE.
  - All counters go to 0.
  - `busy`=0, `match_done`=0, `match_result`=01, `err`=0.
  - Reset overrides every other input.
- Start, in any state: `start`=1 does the following.
  - Clears all four counters and `err`.
  - Sets `match_result`=01.
  - Moves to PLAY.
  - `start` has priority over a same-cycle `round_valid`; that round is discarded.
- IDLE: `round_valid` is ignored.
- PLAY, on `round_valid`=1 with `start`=0:
  - 00: `user_score`+1, `round_count`+1.
  - 11: `comp_score`+1, `round_count`+1.
  - 01: `draw_count`+1, `round_count`+1.
  - 10: no counter changes; `err`<=1. State stays PLAY.
- Match end: if the updated `user_score` or `comp_score` equals `WIN_TARGET`:
  - Next state is DONE.
  - `match_result` becomes 00 (user) or 11 (computer).
- DONE:
  - All outputs hold.
  - `round_valid` is ignored, including illegal codes; `err` does not change.
  - Only `start` or reset leaves DONE.
- Saturation: `draw_count` and `round_count` saturate at 2^`CNT_W`-1 and never wrap. Scores cannot exceed `WIN_TARGET`.

## Timing
- All outputs are registered.
- Latency: a round sampled at edge N is reflected in the counters, `err`, `match_done` and `match_result` right after edge N.
- The final score and `match_done`=1 appear in the same cycle.
- `round_valid` may be asserted on consecutive cycles; every cycle is processed, with no backpressure.
- After `start` at edge N: `busy`=1, counters=0 and `match_done`=0 right after edge N. A `round_valid` at edge N+1 is scored.
- Reset mid-match: IDLE and reset values right after that edge. The partial match is lost.

## Configuration
- `RPS_ROUND_LIMIT_EN` defined:
  - In PLAY, when a legal round makes `round_count` equal `MAX_ROUNDS` and no side has reached `WIN_TARGET`, the next state is DONE.
  - `match_result` then goes to 00 if `user_score` > `comp_score`, 11 if lower, 01 if equal (compared after the update).
  - If `WIN_TARGET` is reached on that same round, the target rule decides.
- `RPS_ROUND_LIMIT_EN` undefined:
  - `MAX_ROUNDS` has no effect.
  - A match ends only when `WIN_TARGET` is reached.
  - `round_count` saturates.

## Test plan
- Reset low for 2 cycles, then high. Expect IDLE, all counters 0, `match_result`=01, `busy`=0, `err`=0. Then pulse `round_valid` with `win`=00: counters stay 0.
- `start`, then back-to-back rounds 00, 01, 11, 00, 00 (`WIN_TARGET`=3). Expect `user_score`=3, `comp_score`=1, `draw_count`=1, `round_count`=5. `match_done`=1 and `match_result`=00 right after the 5th edge. A further round 11 is ignored.
- In PLAY, send `win`=10. Expect `err`=1 and counters unchanged. Then send round 11: `comp_score`=1 and `err` stays 1. A later `start` clears `err`.
- In PLAY with score 2-2, assert `start` and `round_valid` (`win`=00) in the same cycle. Expect all counters 0, `busy`=1, no score.
- `RPS_ROUND_LIMIT_EN`, `MAX_ROUNDS`=4: rounds 01, 01, 00, 01. Expect DONE after the 4th round with `match_result`=00. Repeat with 01×4: expect `match_result`=01. Without the macro, the same 01×4 stays in PLAY.
- Mid-match (score 1-1), drop `reset` for 1 cycle. Expect IDLE and all outputs at reset values right after that edge.

Source files
------------

// File: rtl/rps_match_scorer.sv
// rps_match_scorer
//   Match-level scoreboard for the rock-paper-scissors round engine.
//   Tallies user wins, computer wins and draws from one 2-bit outcome per
//   round_valid strobe. The match ends when either side reaches WIN_TARGET.
//   The final result is held until start is asserted again.
//
//   Optional feature (macro RPS_ROUND_LIMIT_EN):
//     The match also ends after MAX_ROUNDS legal rounds. The side with the
//     higher score then wins; equal scores give 01 (no winner).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous reset, active low
//   start        in   begin/restart a match (beats same-cycle round_valid)
//   round_valid  in   win carries a round outcome this cycle
//   win[1:0]     in   00 user, 01 draw, 11 computer, 10 illegal
//   user_score   out  user round wins this match
//   comp_score   out  computer round wins this match
//   draw_count   out  drawn rounds (saturating)
//   round_count  out  legal rounds scored (saturating)
//   busy         out  match in progress (PLAY)
//   match_done   out  match finished (DONE)
//   match_result out  winner, encoded like win; 01 = no winner
//   err          out  sticky: illegal code seen while in PLAY
module rps_match_scorer #(
  parameter int WIN_TARGET = 3,
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             round_valid,
  input  logic [1:0]       win,
  output logic [CNT_W-1:0] user_score,
  output logic [CNT_W-1:0] comp_score,
  output logic [CNT_W-1:0] draw_count,
  output logic [CNT_W-1:0] round_count,
  output logic             busy,
  output logic             match_done,
  output logic [1:0]       match_result,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] WT = CNT_W'(WIN_TARGET);
`ifdef RPS_ROUND_LIMIT_EN
  localparam logic [CNT_W-1:0] MR = CNT_W'(MAX_ROUNDS);
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] user_q, user_d, comp_q, comp_d;
  logic [CNT_W-1:0] draw_q, draw_d, rnd_q, rnd_d;
  logic [1:0]       res_q, res_d;
  logic             err_q, err_d;
  logic             busy_q, done_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    user_d  = user_q;
    comp_d  = comp_q;
    draw_d  = draw_q;
    rnd_d   = rnd_q;
    res_d   = res_q;
    err_d   = err_q;
    if (start) begin
      // Restart from any state; a same-cycle round is dropped.
      state_d = S_PLAY;
      user_d  = '0;
      comp_d  = '0;
      draw_d  = '0;
      rnd_d   = '0;
      res_d   = 2'b01;
      err_d   = 1'b0;
    end else if (state_q == S_PLAY && round_valid) begin
      if (win == 2'b10) begin
        err_d = 1'b1;
      end else begin
        rnd_d = sat_inc(rnd_q);
        case (win)
          2'b00:   user_d = user_q + 1'b1;
          2'b11:   comp_d = comp_q + 1'b1;
          default: draw_d = sat_inc(draw_q);
        endcase
        // Scores are checked on the updated values so the final score and
        // match_done appear together. Target reach beats the round limit.
        if (user_d == WT) begin
          state_d = S_DONE;
          res_d   = 2'b00;
        end else if (comp_d == WT) begin
          state_d = S_DONE;
          res_d   = 2'b11;
        end
`ifdef RPS_ROUND_LIMIT_EN
        else if (rnd_d == MR) begin
          state_d = S_DONE;
          res_d   = (user_d > comp_d) ? 2'b00 :
                    (user_d < comp_d) ? 2'b11 : 2'b01;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      user_q  <= '0;
      comp_q  <= '0;
      draw_q  <= '0;
      rnd_q   <= '0;
      res_q   <= 2'b01;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      user_q  <= user_d;
      comp_q  <= comp_d;
      draw_q  <= draw_d;
      rnd_q   <= rnd_d;
      res_q   <= res_d;
      err_q   <= err_d;
      // Status flags decoded from the next state so they are registered.
      busy_q  <= (state_d == S_PLAY);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign user_score   = user_q;
  assign comp_score   = comp_q;
  assign draw_count   = draw_q;
  assign round_count  = rnd_q;
  assign busy         = busy_q;
  assign match_done   = done_q;
  assign match_result = res_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Testbench for rps_match_scorer: directed scenarios followed by random
// traffic. A driver applies inputs on the falling edge and pushes the
// expected post-edge outputs from a behavioural model; a monitor pops and
// compares just after every rising edge.
module tb_rps_match_scorer;
  localparam int WT   = 3;
  localparam int CW   = 4;
  localparam int MR   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef RPS_ROUND_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, round_valid;
  logic [1:0] win;
  logic [CW-1:0] user_score, comp_score, draw_count, round_count;
  logic busy, match_done, err;
  logic [1:0] match_result;

  always #5 clk = ~clk;

  rps_match_scorer #(.WIN_TARGET(WT), .CNT_W(CW), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .reset(reset), .start(start), .round_valid(round_valid),
    .win(win), .user_score(user_score), .comp_score(comp_score),
    .draw_count(draw_count), .round_count(round_count), .busy(busy),
    .match_done(match_done), .match_result(match_result), .err(err)
  );

  typedef struct {
    int u, c, d, r, res;
    bit busy, done, err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: phase 0 idle, 1 playing, 2 finished.
  int m_u, m_c, m_d, m_r, m_res, m_ph;
  bit m_err;

  task automatic model(input bit rst, input bit st, input bit rv, input logic [1:0] w);
    if (!rst) begin
      m_u = 0; m_c = 0; m_d = 0; m_r = 0; m_res = 1; m_ph = 0; m_err = 0;
    end else if (st) begin
      m_u = 0; m_c = 0; m_d = 0; m_r = 0; m_res = 1; m_ph = 1; m_err = 0;
    end else if (m_ph == 1 && rv) begin
      if (w == 2'b10) m_err = 1;
      else begin
        if (w == 2'b00) m_u++;
        else if (w == 2'b11) m_c++;
        else if (m_d < CMAX) m_d++;
        if (m_r < CMAX) m_r++;
        if (m_u == WT) begin m_ph = 2; m_res = 0; end
        else if (m_c == WT) begin m_ph = 2; m_res = 3; end
        else if (LIMIT && m_r == MR) begin
          m_ph = 2;
          m_res = (m_u > m_c) ? 0 : (m_u < m_c) ? 3 : 1;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit rv, input logic [1:0] w);
    exp_t e;
    @(negedge clk);
    reset = rst; start = st; round_valid = rv; win = w;
    model(rst, st, rv, w);
    e.u = m_u; e.c = m_c; e.d = m_d; e.r = m_r; e.res = m_res;
    e.busy = (m_ph == 1); e.done = (m_ph == 2); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: every rising edge carries one expected snapshot.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("user_score",   int'(user_score),   e.u);
      chk("comp_score",   int'(comp_score),   e.c);
      chk("draw_count",   int'(draw_count),   e.d);
      chk("round_count",  int'(round_count),  e.r);
      chk("match_result", int'(match_result), e.res);
      chk("busy",         int'(busy),         int'(e.busy));
      chk("match_done",   int'(match_done),   int'(e.done));
      chk("err",          int'(err),          int'(e.err));
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; round_valid = 1'b0; win = 2'b00;
    // Reset, then an ignored round in IDLE.
    step(0, 0, 0, 2'b00);
    step(0, 0, 0, 2'b00);
    step(1, 0, 1, 2'b00);
    step(1, 0, 0, 2'b00);
    // Back-to-back match won by the user, then an ignored round in DONE.
    step(1, 1, 0, 2'b00);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b01);
    step(1, 0, 1, 2'b11);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b11);
    step(1, 0, 1, 2'b10);
    // Illegal code in PLAY, then a legal round; start clears err.
    step(1, 1, 0, 2'b00);
    step(1, 0, 1, 2'b10);
    step(1, 0, 1, 2'b11);
    step(1, 1, 0, 2'b00);
    // Start beats a same-cycle round at 2-2.
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b11);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b11);
    step(1, 1, 1, 2'b00);
    step(1, 0, 1, 2'b11);
    // Round-limit scenarios (stay in PLAY without the macro).
    step(1, 1, 0, 2'b00);
    step(1, 0, 1, 2'b01);
    step(1, 0, 1, 2'b01);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b01);
    step(1, 1, 0, 2'b00);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 2'b01);
    // Long run of draws exercises counter saturation.
    for (int i = 0; i < 14; i++) step(1, 0, 1, 2'b01);
    step(1, 0, 1, 2'b00);
    // Reset mid-match at 1-1.
    step(1, 1, 0, 2'b00);
    step(1, 0, 1, 2'b00);
    step(1, 0, 1, 2'b11);
    step(0, 0, 1, 2'b00);
    step(1, 0, 1, 2'b00);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit rst, st, rv;
      logic [1:0] w;
      rst = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      w   = 2'($urandom_range(0, 3));
      step(rst, st, rv, w);
    end
    step(1, 0, 0, 2'b00);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
